// File: rtl/pool_pkg.sv
// pool_pkg: shared definitions for the max-pooling sequencer and the pooling block.
// Holds the control/config word layout, the FSM state enum, the row-phase enum
// and the helper that builds one slot's control word.
package pool_pkg;

    // Word widths shared with the pooling block
    localparam int CTRL_WIDTH = 7;
    localparam int CFG_WIDTH  = 3;

    // Control word bit positions: {pad_row, pool_valid, mux_sel, rf_pop, push, pop, shift}
    localparam int CTRL_SHIFT   = 0;
    localparam int CTRL_POP     = 1;
    localparam int CTRL_PUSH    = 2;
    localparam int CTRL_RF_POP  = 3;
    localparam int CTRL_MUX_SEL = 4;
    localparam int CTRL_VALID   = 5;
    localparam int CTRL_PAD     = 6;

    // Config word: kernel-size switch sits above the stride field
    localparam int CFG_KERNEL = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WORD,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Position of an input row inside its (non-overlapping) vertical window
    typedef enum logic [1:0] {
        PH_FIRST,
        PH_MID,
        PH_LAST
    } phase_t;

    // Control word for one slot: slot 0 pops a new input word, later slots shift it
    function automatic logic [CTRL_WIDTH-1:0] slot_ctrl(
        input phase_t phase,
        input logic   first_slot,
        input logic   pad
    );
        logic [CTRL_WIDTH-1:0] word;
        word             = '0;
        word[CTRL_PAD]   = pad;
        word[CTRL_POP]   = first_slot;
        word[CTRL_SHIFT] = !first_slot;
        case (phase)
            PH_FIRST: begin
                word[CTRL_MUX_SEL] = 1'b1;
                word[CTRL_PUSH]    = 1'b1;
            end
            PH_MID: begin
                word[CTRL_PUSH]    = 1'b1;
                word[CTRL_RF_POP]  = 1'b1;
            end
            default: begin
                word[CTRL_RF_POP]  = 1'b1;
                word[CTRL_VALID]   = 1'b1;
            end
        endcase
        return word;
    endfunction

endpackage

// File: rtl/pool_ctrl_cnt.sv
// pool_ctrl_cnt: loadable wrap counter. Advances on en, wraps to zero after
// reaching last, and flags the terminal count combinationally.
module pool_ctrl_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] count_reg;

    assign count = count_reg;
    assign tc    = (count_reg == last);

    // Count register: reset, then load, then wrap-increment
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en) begin
            count_reg <= tc ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/pool_ctrl.sv
// pool_ctrl: turns a start command plus a layer descriptor into the per-cycle
// control and config words for the max-pooling block.
// Optional feature macro: POOL_PAD_EN (trailing zero rows, pad_row bit).
// Counters always point at the next slot to issue; the control word for that
// slot is registered on the same edge that advances them, so the first word
// shows up on the cycle right after start is accepted.
module pool_ctrl #(
    parameter int NUM_PE       = 4,
    parameter int CTRL_WIDTH   = 7,
    parameter int CFG_WIDTH    = 3,
    parameter int STRIDE_WIDTH = 2,
    parameter int DIM_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    cfg_kernel3,
    input  logic [STRIDE_WIDTH-1:0] cfg_stride,
    input  logic [DIM_WIDTH-1:0]    cfg_row_words,
    input  logic [DIM_WIDTH-1:0]    cfg_out_rows,
    input  logic [1:0]              cfg_pad_rows,
    input  logic                    pool_ready,
    input  logic                    read_ready,
    output logic [CTRL_WIDTH-1:0]   ctrl,
    output logic [CFG_WIDTH-1:0]    cfg,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    import pool_pkg::*;

    localparam int TW       = DIM_WIDTH + 2;
    localparam int NCNT     = 4;
    localparam int CNT_SLOT = 0;
    localparam int CNT_WORD = 1;
    localparam int CNT_ROW  = 2;
    localparam int CNT_WIN  = 3;
    localparam logic [DIM_WIDTH-1:0] SLOT_LAST_S1 = DIM_WIDTH'(NUM_PE - 1);
    localparam logic [DIM_WIDTH-1:0] SLOT_LAST_S2 = DIM_WIDTH'(NUM_PE / 2 - 1);

    state_t                  state_reg, state_next;
    logic [CTRL_WIDTH-1:0]   ctrl_reg, ctrl_next;
    logic [CFG_WIDTH-1:0]    cfg_reg;
    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;
    logic                    err_reg, err_next;
    logic [DIM_WIDTH-1:0]    row_words_reg, out_rows_reg;

    // Descriptor in effect: raw inputs while idle (start cycle), latched copy otherwise
    logic                    in_idle;
    logic                    eff_k3;
    logic [STRIDE_WIDTH-1:0] eff_stride;
    logic [DIM_WIDTH-1:0]    eff_row_words, eff_out_rows;
    logic [DIM_WIDTH-1:0]    kh;
    logic [TW-1:0]           total_rows, row_index;

    logic                    legal, pad_now, slot0, gate;
    logic                    start_ok, active, issue, final_slot, load_cnt;
    phase_t                  phase;

    logic [DIM_WIDTH-1:0]    cnt_last [NCNT];
    logic [DIM_WIDTH-1:0]    cnt_val  [NCNT];
    logic [NCNT-1:0]         cnt_en, cnt_tc;

`ifdef POOL_PAD_EN
    logic [1:0]              pad_rows_reg;
    logic [1:0]              eff_pad_rows;
    assign eff_pad_rows = in_idle ? cfg_pad_rows : pad_rows_reg;
`else
    logic [1:0]              unused_pad_rows;
    assign unused_pad_rows = cfg_pad_rows;
`endif

    assign ctrl = ctrl_reg;
    assign cfg  = cfg_reg;
    assign busy = busy_reg;
    assign done = done_reg;
    assign err  = err_reg;

    assign in_idle       = (state_reg == ST_IDLE);
    assign eff_k3        = in_idle ? cfg_kernel3   : cfg_reg[CFG_KERNEL];
    assign eff_stride    = in_idle ? cfg_stride    : cfg_reg[STRIDE_WIDTH-1:0];
    assign eff_row_words = in_idle ? cfg_row_words : row_words_reg;
    assign eff_out_rows  = in_idle ? cfg_out_rows  : out_rows_reg;

    // Slot, word, row and window counters; each advances when all lower ones wrap
    genvar gi;
    generate
        for (gi = 0; gi < NCNT; gi++) begin : g_cnt
            if (gi == 0) begin : g_en_first
                assign cnt_en[gi] = issue;
            end else begin : g_en_chain
                assign cnt_en[gi] = issue & (&cnt_tc[gi-1:0]);
            end
            pool_ctrl_cnt #(.WIDTH(DIM_WIDTH)) u_cnt (
                .clk      (clk),
                .reset    (reset),
                .load     (load_cnt),
                .load_val ('0),
                .en       (cnt_en[gi]),
                .last     (cnt_last[gi]),
                .count    (cnt_val[gi]),
                .tc       (cnt_tc[gi])
            );
        end
    endgenerate

    assign final_slot = &cnt_tc;

    // Window geometry, legality, pad detection and row phase for the pending slot
    always_comb begin
        kh                 = eff_k3 ? DIM_WIDTH'(3) : DIM_WIDTH'(2);
        total_rows         = TW'(eff_out_rows) * TW'(kh);
        row_index          = TW'(cnt_val[CNT_WIN]) * TW'(kh) + TW'(cnt_val[CNT_ROW]);
        cnt_last[CNT_SLOT] = (eff_stride == STRIDE_WIDTH'(2)) ? SLOT_LAST_S2 : SLOT_LAST_S1;
        cnt_last[CNT_WORD] = eff_row_words - 1'b1;
        cnt_last[CNT_ROW]  = kh - 1'b1;
        cnt_last[CNT_WIN]  = eff_out_rows - 1'b1;
        legal = ((eff_stride == STRIDE_WIDTH'(1)) || (eff_stride == STRIDE_WIDTH'(2))) &&
                (eff_row_words != '0) && (eff_out_rows != '0);
`ifdef POOL_PAD_EN
        legal   = legal && (TW'(eff_pad_rows) < total_rows);
        pad_now = (row_index + TW'(eff_pad_rows)) >= total_rows;
`else
        pad_now = 1'b0;
`endif
        if (cnt_val[CNT_ROW] == '0) begin
            phase = PH_FIRST;
        end else if (cnt_tc[CNT_ROW]) begin
            phase = PH_LAST;
        end else begin
            phase = PH_MID;
        end
        slot0    = (cnt_val[CNT_SLOT] == '0);
        gate     = pad_now || (pool_ready && ((phase != PH_LAST) || read_ready));
        start_ok = in_idle && start && legal;
        active   = start_ok || (state_reg == ST_WORD) || (state_reg == ST_WAIT);
        issue    = active && (!slot0 || gate);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_next = state_reg;
        ctrl_next  = '0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        load_cnt   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                load_cnt = !issue;
                if (start && !legal) begin
                    err_next  = 1'b1;
                    done_next = 1'b1;
                end
            end
            ST_DONE: begin
                done_next  = 1'b1;
                load_cnt   = 1'b1;
                state_next = ST_IDLE;
            end
            default: ;
        endcase
        if (active) begin
            if (issue) begin
                ctrl_next  = slot_ctrl(phase, slot0, pad_now);
                state_next = final_slot ? ST_DONE : ST_WORD;
            end else begin
                state_next = ST_WAIT;
            end
        end
        busy_next = (state_next != ST_IDLE);
    end

    // Registered outputs and descriptor latch
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_reg      <= '0;
            cfg_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            row_words_reg <= '0;
            out_rows_reg  <= '0;
`ifdef POOL_PAD_EN
            pad_rows_reg  <= '0;
`endif
        end else begin
            ctrl_reg <= ctrl_next;
            busy_reg <= busy_next;
            done_reg <= done_next;
            err_reg  <= err_next;
            if (start_ok) begin
                cfg_reg       <= {cfg_kernel3, cfg_stride};
                row_words_reg <= cfg_row_words;
                out_rows_reg  <= cfg_out_rows;
`ifdef POOL_PAD_EN
                pad_rows_reg  <= cfg_pad_rows;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pool_ctrl.sv
// tb_pool_ctrl: directed self-checking bench for pool_ctrl.
// Pad-row scenario runs when POOL_PAD_EN is defined; otherwise it checks that
// the pad field is ignored.
module tb_pool_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       cfg_kernel3 = 1'b0;
    logic [1:0] cfg_stride = 2'd0;
    logic [7:0] cfg_row_words = 8'd0;
    logic [7:0] cfg_out_rows = 8'd0;
    logic [1:0] cfg_pad_rows = 2'd0;
    logic       pool_ready = 1'b1;
    logic       read_ready = 1'b1;
    logic [6:0] ctrl;
    logic [2:0] cfg;
    logic       busy, done, err;

    int checks = 0;
    int passed = 0;

    pool_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_kernel3  (cfg_kernel3),
        .cfg_stride   (cfg_stride),
        .cfg_row_words(cfg_row_words),
        .cfg_out_rows (cfg_out_rows),
        .cfg_pad_rows (cfg_pad_rows),
        .pool_ready   (pool_ready),
        .read_ready   (read_ready),
        .ctrl         (ctrl),
        .cfg          (cfg),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input logic k3, input logic [1:0] st, input logic [7:0] rw,
                            input logic [7:0] orows, input logic [1:0] pad);
        cfg_kernel3   = k3;
        cfg_stride    = st;
        cfg_row_words = rw;
        cfg_out_rows  = orows;
        cfg_pad_rows  = pad;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        set_desc(1'b1, 2'd1, 8'd4, 8'd4, 2'd0);
        step();
        step();
        checks++; if (ctrl !== 7'h00) $display("FAIL reset_ctrl got %h want 00", ctrl); else passed++;
        checks++; if (cfg !== 3'b000) $display("FAIL reset_cfg got %b want 000", cfg); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passed++;
        reset = 1'b0;
        start = 1'b0;
        step();
        checks++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b want 0", busy); else passed++;
        $display("reset: outputs cleared");
    endtask

    task automatic test_basic();
        logic [6:0] exp_seq [16];
        logic [6:0] want;
        exp_seq = '{7'h16, 7'h15, 7'h16, 7'h15, 7'h2A, 7'h29, 7'h2A, 7'h29,
                    7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        set_desc(1'b0, 2'd2, 8'd2, 8'd1, 2'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (cfg !== 3'b010) $display("FAIL basic_cfg got %b want 010", cfg); else passed++;
        for (int c = 1; c <= 9; c++) begin
            want = (c <= 8) ? exp_seq[c-1] : 7'h00;
            checks++; if (ctrl !== want) $display("FAIL basic_ctrl c%0d got %h want %h", c, ctrl, want); else passed++;
            checks++; if (done !== (c == 9)) $display("FAIL basic_done c%0d got %b want %b", c, done, (c == 9)); else passed++;
            checks++; if (busy !== (c <= 8)) $display("FAIL basic_busy c%0d got %b want %b", c, busy, (c <= 8)); else passed++;
            if (c < 9) step();
        end
        step();
        checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done); else passed++;
        $display("basic: kh=2 stride=2 words=2 rows=1 run of 8 slots");
    endtask

    task automatic test_kernel3_back_to_back();
        logic [6:0] exp_seq [16];
        logic [6:0] want;
        exp_seq = '{7'h16, 7'h15, 7'h15, 7'h15, 7'h0E, 7'h0D, 7'h0D, 7'h0D,
                    7'h2A, 7'h29, 7'h29, 7'h29, 7'h00, 7'h00, 7'h00, 7'h00};
        set_desc(1'b1, 2'd1, 8'd1, 8'd1, 2'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (cfg !== 3'b101) $display("FAIL k3_cfg got %b want 101", cfg); else passed++;
        for (int c = 1; c <= 13; c++) begin
            want = (c <= 12) ? exp_seq[c-1] : 7'h00;
            checks++; if (ctrl !== want) $display("FAIL k3_ctrl c%0d got %h want %h", c, ctrl, want); else passed++;
            checks++; if (done !== (c == 13)) $display("FAIL k3_done c%0d got %b want %b", c, done, (c == 13)); else passed++;
            checks++; if (err !== 1'b0) $display("FAIL k3_err c%0d got %b want 0", c, err); else passed++;
            // A second start with a different descriptor mid-run must be ignored
            if (c == 4) begin
                set_desc(1'b0, 2'd3, 8'd5, 8'd5, 2'd0);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (c < 13) step();
        end
        checks++; if (cfg !== 3'b101) $display("FAIL k3_cfg_hold got %b want 101", cfg); else passed++;
        $display("kernel3: kh=3 stride=1 run of 12 slots with ignored restart");
    endtask

    task automatic test_stall();
        logic [6:0] exp_seq [16];
        logic [6:0] want;
        exp_seq = '{7'h16, 7'h15, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h16,
                    7'h15, 7'h00, 7'h00, 7'h2A, 7'h29, 7'h2A, 7'h29, 7'h00};
        set_desc(1'b0, 2'd2, 8'd2, 8'd1, 2'd0);
        pool_ready = 1'b1;
        read_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            want = exp_seq[c-1];
            checks++; if (ctrl !== want) $display("FAIL stall_ctrl c%0d got %h want %h", c, ctrl, want); else passed++;
            checks++; if (done !== (c == 16)) $display("FAIL stall_done c%0d got %b want %b", c, done, (c == 16)); else passed++;
            checks++; if (busy !== (c <= 15)) $display("FAIL stall_busy c%0d got %b want %b", c, busy, (c <= 15)); else passed++;
            pool_ready = !(c >= 2 && c <= 6);
            read_ready = !(c >= 9 && c <= 10);
            if (c < 16) step();
        end
        pool_ready = 1'b1;
        read_ready = 1'b1;
        $display("stall: 5 pool_ready waits and 2 read_ready waits");
    endtask

    task automatic test_pad();
        logic [6:0] exp_seq [8];
        logic [6:0] want;
`ifdef POOL_PAD_EN
        exp_seq = '{7'h16, 7'h15, 7'h2A, 7'h29, 7'h16, 7'h15, 7'h6A, 7'h69};
`else
        exp_seq = '{7'h16, 7'h15, 7'h2A, 7'h29, 7'h16, 7'h15, 7'h2A, 7'h29};
`endif
        set_desc(1'b0, 2'd2, 8'd1, 8'd2, 2'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            want = (c <= 8) ? exp_seq[c-1] : 7'h00;
            checks++; if (ctrl !== want) $display("FAIL pad_ctrl c%0d got %h want %h", c, ctrl, want); else passed++;
            checks++; if (done !== (c == 9)) $display("FAIL pad_done c%0d got %b want %b", c, done, (c == 9)); else passed++;
`ifdef POOL_PAD_EN
            pool_ready = (c < 5);
`endif
            if (c < 9) step();
        end
        pool_ready = 1'b1;
        $display("pad: kh=2 rows=2 pad_rows=1");
    endtask

    task automatic test_err();
        set_desc(1'b0, 2'd3, 8'd1, 8'd1, 2'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (err !== 1'b1) $display("FAIL err_stride got %b want 1", err); else passed++;
        checks++; if (done !== 1'b1) $display("FAIL err_stride_done got %b want 1", done); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL err_stride_busy got %b want 0", busy); else passed++;
        checks++; if (ctrl !== 7'h00) $display("FAIL err_stride_ctrl got %h want 00", ctrl); else passed++;
        step();
        checks++; if (err !== 1'b0) $display("FAIL err_pulse got %b want 0", err); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL err_done_pulse got %b want 0", done); else passed++;
        checks++; if (ctrl !== 7'h00) $display("FAIL err_idle_ctrl got %h want 00", ctrl); else passed++;
        set_desc(1'b0, 2'd1, 8'd0, 8'd1, 2'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (err !== 1'b1) $display("FAIL err_zero_words got %b want 1", err); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL err_zero_busy got %b want 0", busy); else passed++;
        set_desc(1'b0, 2'd2, 8'd1, 8'd1, 2'd2);
        start = 1'b1;
        step();
        start = 1'b0;
`ifdef POOL_PAD_EN
        checks++; if (err !== 1'b1) $display("FAIL err_pad_all got %b want 1", err); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL err_pad_busy got %b want 0", busy); else passed++;
`else
        checks++; if (err !== 1'b0) $display("FAIL err_pad_ignored got %b want 0", err); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL err_pad_busy got %b want 1", busy); else passed++;
        for (int c = 2; c <= 5; c++) step();
        checks++; if (done !== 1'b1) $display("FAIL err_pad_run_done got %b want 1", done); else passed++;
`endif
        step();
        $display("err: illegal descriptors rejected");
    endtask

    task automatic test_reset_mid();
        logic [6:0] exp_seq [8];
        logic [6:0] want;
        exp_seq = '{7'h16, 7'h15, 7'h16, 7'h15, 7'h2A, 7'h29, 7'h2A, 7'h29};
        set_desc(1'b0, 2'd2, 8'd2, 8'd1, 2'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (ctrl !== 7'h00) $display("FAIL midrst_ctrl got %h want 00", ctrl); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passed++;
        checks++; if (cfg !== 3'b000) $display("FAIL midrst_cfg got %b want 000", cfg); else passed++;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            want = (c <= 8) ? exp_seq[c-1] : 7'h00;
            checks++; if (ctrl !== want) $display("FAIL midrst_ctrl c%0d got %h want %h", c, ctrl, want); else passed++;
            checks++; if (done !== (c == 9)) $display("FAIL midrst_done c%0d got %b want %b", c, done, (c == 9)); else passed++;
            if (c < 9) step();
        end
        step();
        $display("reset_mid: restart after mid-row reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_kernel3_back_to_back();
        test_stall();
        test_pad();
        test_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
